// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the MAC dot-product sequencer.
package mac_seq_pkg;

  localparam int unsigned DEF_DATA_W  = 4;
  localparam int unsigned DEF_MAX_LEN = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // Width able to hold a pair count from 0 to max_len inclusive
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/mac_seq_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module mac_seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer in front of the MAC: clear, stream pairs, wait out latency, hold result.
// Defining MAC_SEQ_TIMEOUT_EN adds a stall timeout in STREAM that ends the command with res_err=1.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter  int unsigned DATA_W      = DEF_DATA_W,
  parameter  int unsigned MAX_LEN     = DEF_MAX_LEN,
  parameter  int unsigned MAC_LAT     = 1,
  parameter  int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned LEN_W       = len_w(MAX_LEN)
) (
  input  logic              sys_clock,
  input  logic              sys_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [LEN_W-1:0]  res_count,
  output logic              res_err,
  output logic              mac_sclr,
  output logic              mac_load,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [DATA_W-1:0] mac_out,
  output logic              busy
);

  localparam int unsigned DRAIN_W = $clog2(MAC_LAT + 2);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t             state, state_d;
  logic [LEN_W-1:0]   len_q, len_d, count_q, count_d, res_count_d;
  logic [DATA_W-1:0]  mac_a_d, mac_b_d, res_data_d;
  logic               mac_sclr_d, mac_load_d, res_valid_d;
  logic               cmd_ready_d, op_ready_d, busy_d;
  logic               drain_load, drain_zero, stall_load;

  // Drain wait: loaded with MAC_LAT gives MAC_LAT+1 cycles in DRAIN
  mac_seq_timer #(.W(DRAIN_W)) u_drain_timer (
    .clk      (sys_clock),
    .rst_n    (sys_reset_n),
    .load     (drain_load),
    .load_val (DRAIN_W'(MAC_LAT)),
    .en       (state == DRAIN),
    .zero_c   (drain_zero)
  );

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic err_q, err_d, res_err_d, stall_zero;

  // Counts consecutive idle STREAM cycles; reloaded on entry and on every handshake
  mac_seq_timer #(.W(STALL_W)) u_stall_timer (
    .clk      (sys_clock),
    .rst_n    (sys_reset_n),
    .load     (stall_load),
    .load_val (STALL_W'(TIMEOUT_CYC - 1)),
    .en       ((state == STREAM) && !op_valid),
    .zero_c   (stall_zero)
  );

  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      err_q   <= 1'b0;
      res_err <= 1'b0;
    end else begin
      err_q   <= err_d;
      res_err <= res_err_d;
    end
  end
`else
  assign res_err = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    len_d       = len_q;
    count_d     = count_q;
    mac_sclr_d  = 1'b0;
    mac_load_d  = 1'b0;
    mac_a_d     = '0;
    mac_b_d     = '0;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_count_d = res_count;
    drain_load  = 1'b0;
    stall_load  = 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
    err_d       = err_q;
    res_err_d   = res_err;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          len_d      = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
          count_d    = '0;
          mac_sclr_d = 1'b1;
          state_d    = CLEAR;
`ifdef MAC_SEQ_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
      end
      CLEAR: begin
        if (len_q == '0) begin
          drain_load = 1'b1;
          state_d    = DRAIN;
        end else begin
          stall_load = 1'b1;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (op_valid && op_ready) begin
          mac_load_d = 1'b1;
          mac_a_d    = op_a;
          mac_b_d    = op_b;
          count_d    = count_q + LEN_W'(1);
          stall_load = 1'b1;
          if (count_q == len_q - LEN_W'(1)) begin
            drain_load = 1'b1;
            state_d    = DRAIN;
          end
        end
`ifdef MAC_SEQ_TIMEOUT_EN
        else if (stall_zero) begin
          err_d      = 1'b1;
          drain_load = 1'b1;
          state_d    = DRAIN;
        end
`endif
      end
      DRAIN: begin
        if (drain_zero) begin
          res_valid_d = 1'b1;
          res_data_d  = mac_out;
          res_count_d = count_q;
`ifdef MAC_SEQ_TIMEOUT_EN
          res_err_d   = err_q;
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    op_ready_d  = (state_d == STREAM);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state     <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      cmd_ready <= 1'b1;
      op_ready  <= 1'b0;
      busy      <= 1'b0;
      mac_sclr  <= 1'b0;
      mac_load  <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
    end else begin
      state     <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      cmd_ready <= cmd_ready_d;
      op_ready  <= op_ready_d;
      busy      <= busy_d;
      mac_sclr  <= mac_sclr_d;
      mac_load  <= mac_load_d;
      mac_a     <= mac_a_d;
      mac_b     <= mac_b_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      res_count <= res_count_d;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural 4-bit MAC attached.
// Define MAC_SEQ_TIMEOUT_EN for both bench and RTL to exercise the stall timeout.
module tb_mac_seq_ctrl;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LEN_W   = 5;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid, cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              op_valid, op_ready;
  logic [DATA_W-1:0] op_a, op_b;
  logic              res_valid, res_ready, res_err;
  logic [DATA_W-1:0] res_data;
  logic [LEN_W-1:0]  res_count;
  logic              mac_sclr, mac_load;
  logic [DATA_W-1:0] mac_a, mac_b, mac_out;
  logic              busy;

  int n_checks = 0;
  int n_err    = 0;
  int sclr_cnt = 0;
  int load_cnt = 0;
  int pa [0:19];
  int pb [0:19];

  mac_seq_ctrl dut (
    .sys_clock   (clk),
    .sys_reset_n (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_count   (res_count),
    .res_err     (res_err),
    .mac_sclr    (mac_sclr),
    .mac_load    (mac_load),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_out     (mac_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: sync clear, accumulate a*b mod 16, one-cycle latency
  logic [DATA_W-1:0] acc;
  always @(posedge clk) begin
    if (mac_sclr === 1'b1) acc <= '0;
    else if (mac_load === 1'b1) acc <= acc + DATA_W'(mac_a * mac_b);
  end
  assign mac_out = acc;

  always @(posedge clk) begin
    if (rst_n === 1'b1 && mac_sclr === 1'b1) sclr_cnt++;
    if (rst_n === 1'b1 && mac_load === 1'b1) load_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input int len);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("cmd_accept_bound", 32'(k < 50), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_ready_after_accept", cmd_ready, 0);
    check("sclr_in_clear", mac_sclr, 1);
  endtask

  task automatic stream(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      if (gap > 0) begin
        op_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      op_valid = 1'b1;
      op_a     = DATA_W'(pa[i]);
      op_b     = DATA_W'(pb[i]);
      while (op_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) check("op_accept_bound", 32'(k), 0);
      @(negedge clk);
    end
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
  endtask

  task automatic wait_result(input int exp_data, input int exp_count, input int exp_err,
                             input int hold);
    int k = 0;
    while (res_valid !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    check("res_valid_seen", res_valid, 1);
    check("res_data", res_data, 32'(exp_data));
    check("res_count", res_count, 32'(exp_count));
    check("res_err", res_err, 32'(exp_err));
    check("op_ready_in_done", op_ready, 0);
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("res_hold_valid", res_valid, 1);
      check("res_hold_data", res_data, 32'(exp_data));
      check("res_hold_count", res_count, 32'(exp_count));
      check("cmd_ready_while_done", cmd_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_dropped", res_valid, 0);
    check("cmd_ready_back_idle", cmd_ready, 1);
    check("busy_idle", busy, 0);
  endtask

  // Expected result is the plain modular dot product of the pairs actually sent
  task automatic run_cmd(input int len_in, input int n_send, input int gap, input int hold,
                         input int exp_err);
    int s0 = sclr_cnt;
    int l0 = load_cnt;
    int sum = 0;
    for (int i = 0; i < n_send; i++) sum += pa[i] * pb[i];
    send_cmd(len_in);
    stream(n_send, gap);
    wait_result(sum % 16, n_send, exp_err, hold);
    check("sclr_pulses", 32'(sclr_cnt - s0), 1);
    check("load_pulses", 32'(load_cnt - l0), 32'(n_send));
  endtask

  initial begin
    int len_in, n, gap, hold;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mac_ctrl", {mac_sclr, mac_load, mac_a, mac_b}, 0);
    check("rst_res", {res_data, res_count, res_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4; pa[2] = 2; pb[2] = 2;
    run_cmd(3, 3, 0, 0, 0);

    run_cmd(0, 0, 0, 1, 0);

    for (int i = 0; i < 2; i++) begin pa[i] = int'($urandom_range(0, 15)); pb[i] = int'($urandom_range(0, 15)); end
    run_cmd(2, 2, 3, 5, 0);

    // Reset in the middle of STREAM abandons the command
    pa[0] = 5; pb[0] = 7; pa[1] = 6; pb[1] = 3;
    send_cmd(4);
    stream(2, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_op_ready", op_ready, 0);
    check("midrst_mac", {mac_sclr, mac_load, mac_a, mac_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_result", res_valid, 0);
    pa[0] = 3; pb[0] = 3;
    run_cmd(1, 1, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin pa[i] = 1; pb[i] = 1; end
    send_cmd(20);
    stream(16, 0);
    check("clamp_op_ready_after_16", op_ready, 0);
    wait_result(0, 16, 0, 0);

    for (int t = 0; t < 8; t++) begin
      len_in = int'($urandom_range(0, 20));
      n      = (len_in > int'(MAX_LEN)) ? int'(MAX_LEN) : len_in;
      gap    = int'($urandom_range(0, 3));
      hold   = int'($urandom_range(0, 3));
      for (int i = 0; i < 20; i++) begin
        pa[i] = int'($urandom_range(0, 15));
        pb[i] = int'($urandom_range(0, 15));
      end
      run_cmd(len_in, n, gap, hold, 0);
    end

`ifdef MAC_SEQ_TIMEOUT_EN
    pa[0] = 2; pb[0] = 3; pa[1] = 2; pb[1] = 3;
    send_cmd(4);
    stream(2, 0);
    repeat (60) @(negedge clk);
    check("timeout_not_early", res_valid, 0);
    wait_result(12, 2, 1, 2);
`else
    pa[0] = 4; pb[0] = 4; pa[1] = 1; pb[1] = 5;
    send_cmd(2);
    stream(1, 0);
    repeat (80) @(negedge clk);
    check("stall_waits_valid", res_valid, 0);
    check("stall_waits_ready", op_ready, 1);
    pa[0] = 1; pb[0] = 5;
    stream(1, 0);
    wait_result(5, 2, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
